// File: rtl/fetch_pc_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pc_ctrl_pkg
//   Shared types and constants for the fetch PC controller.
//   - fetch_state_e : controller state (IDLE/RUN/MISS/RECOVER), 2 bits
//   - BUNDLE_BYTES  : sequential PC step per fetch bundle
//   - CNT_W         : width of the post-recovery bubble counter
//   - sat_inc16     : saturating 16-bit increment
// ---------------------------------------------------------------------------
package fetch_pc_ctrl_pkg;

  localparam int SIZE_PC_DEF         = 32;
  localparam int FETCH_BANDWIDTH     = 4;
  localparam int INST_BYTES          = 8;
  localparam int BUNDLE_BYTES        = FETCH_BANDWIDTH * INST_BYTES;
  localparam int RECOVER_BUBBLES_DEF = 2;
  localparam int CNT_W               = 4;   // holds RECOVER_BUBBLES up to 15

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_MISS    = 2'd2,
    ST_RECOVER = 2'd3
  } fetch_state_e;

  // Recovery event counter saturates instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : (v + 16'd1);
  endfunction

endpackage

// File: rtl/fetch_pc_ctrl_if.sv
// ---------------------------------------------------------------------------
// fetch_pc_ctrl_if
//   Redirect / BTB / I-cache / FS1 signal bundle around the fetch PC
//   controller. The slave modport is the controller view, master is the
//   environment (EX, FS2, BTB, I-cache, FS1) view.
// ---------------------------------------------------------------------------
interface fetch_pc_ctrl_if #(
  parameter int SIZE_PC = 32
);
  logic               stall_i;
  logic               flagRecoverEX_i;
  logic [SIZE_PC-1:0] targetAddrEX_i;
  logic               flagRecoverID_i;
  logic [SIZE_PC-1:0] targetAddrID_i;
  logic               btbTaken_i;
  logic [SIZE_PC-1:0] btbTarget_i;
  logic               icacheMiss_i;
  logic               icacheFill_i;
  logic [SIZE_PC-1:0] pc_o;
  logic               fetchEn_o;
  logic               flushFS1_o;
  logic               flushFS2_o;
  logic               icacheCancel_o;
  logic [15:0]        recoverCount_o;

  modport slave (
    input  stall_i, flagRecoverEX_i, targetAddrEX_i, flagRecoverID_i,
           targetAddrID_i, btbTaken_i, btbTarget_i, icacheMiss_i, icacheFill_i,
    output pc_o, fetchEn_o, flushFS1_o, flushFS2_o, icacheCancel_o,
           recoverCount_o
  );

  modport master (
    output stall_i, flagRecoverEX_i, targetAddrEX_i, flagRecoverID_i,
           targetAddrID_i, btbTaken_i, btbTarget_i, icacheMiss_i, icacheFill_i,
    input  pc_o, fetchEn_o, flushFS1_o, flushFS2_o, icacheCancel_o,
           recoverCount_o
  );
endinterface

// File: rtl/fetch_pc_ctrl_next_pc_mux.sv
// ---------------------------------------------------------------------------
// fetch_next_pc_mux
//   Combinational next-PC priority select and squash decode.
//   Priority in RUN: EX recovery > I-cache miss > stall > ID recovery >
//   BTB taken > sequential. In MISS/RECOVER only an EX recovery moves the PC.
//   Ports: state_i, event inputs and pc_i in; pc_next_o, take_ex_o (EX
//   redirect accepted), fetchEn_o, flushFS1_o, flushFS2_o, icacheCancel_o out.
// ---------------------------------------------------------------------------
module fetch_next_pc_mux
  import fetch_pc_ctrl_pkg::*;
#(
  parameter int SIZE_PC = 32
) (
  input  fetch_state_e       state_i,
  input  logic               stall_i,
  input  logic               flagRecoverEX_i,
  input  logic [SIZE_PC-1:0] targetAddrEX_i,
  input  logic               flagRecoverID_i,
  input  logic [SIZE_PC-1:0] targetAddrID_i,
  input  logic               btbTaken_i,
  input  logic [SIZE_PC-1:0] btbTarget_i,
  input  logic               icacheMiss_i,
  input  logic [SIZE_PC-1:0] pc_i,
  output logic [SIZE_PC-1:0] pc_next_o,
  output logic               take_ex_o,
  output logic               fetchEn_o,
  output logic               flushFS1_o,
  output logic               flushFS2_o,
  output logic               icacheCancel_o
);

  // Next-PC priority select and flush/cancel decode.
  always_comb begin
    pc_next_o      = pc_i;
    take_ex_o      = 1'b0;
    flushFS1_o     = 1'b0;
    flushFS2_o     = 1'b0;
    icacheCancel_o = 1'b0;
    fetchEn_o      = (state_i == ST_RUN) & ~stall_i & ~icacheMiss_i;
    case (state_i)
      ST_RUN: begin
        if (flagRecoverEX_i) begin
          pc_next_o  = targetAddrEX_i;
          take_ex_o  = 1'b1;
          flushFS1_o = 1'b1;
          flushFS2_o = 1'b1;
        end else if (icacheMiss_i || stall_i) begin
          pc_next_o = pc_i;
        end else if (flagRecoverID_i) begin
          pc_next_o  = targetAddrID_i;
          flushFS1_o = 1'b1;
        end else if (btbTaken_i) begin
          pc_next_o = btbTarget_i;
        end else begin
          // Sequential step wraps modulo 2^SIZE_PC.
          pc_next_o = pc_i + SIZE_PC'(BUNDLE_BYTES);
        end
      end
      ST_MISS, ST_RECOVER: begin
        if (flagRecoverEX_i) begin
          pc_next_o      = targetAddrEX_i;
          take_ex_o      = 1'b1;
          flushFS1_o     = 1'b1;
          flushFS2_o     = 1'b1;
          // Only a pending miss has anything to cancel.
          icacheCancel_o = (state_i == ST_MISS);
        end else begin
          pc_next_o = pc_i;
        end
      end
      default: begin
        // IDLE: nothing is in flight, so redirects are not acted on.
        pc_next_o = pc_i;
      end
    endcase
  end

endmodule

// File: rtl/fetch_pc_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_pc_ctrl
//   Owns the fetch PC and sequences FS1/FS2: I-cache miss wait, post-EX
//   recovery bubbles and squash lines.
//   Ports: clk, reset (async, active-high); bus (fetch_pc_ctrl_if.slave)
//   carrying stall/redirect/BTB/I-cache inputs and pc_o, fetchEn_o,
//   flushFS1_o, flushFS2_o, icacheCancel_o, recoverCount_o outputs.
// ---------------------------------------------------------------------------
module fetch_pc_ctrl
  import fetch_pc_ctrl_pkg::*;
#(
  parameter int                 SIZE_PC         = SIZE_PC_DEF,
  parameter logic [SIZE_PC-1:0] RESET_PC        = SIZE_PC'(32'h0040_0000),
  parameter int                 RECOVER_BUBBLES = RECOVER_BUBBLES_DEF
) (
  input  logic              clk,
  input  logic              reset,
  fetch_pc_ctrl_if.slave    bus
);

  fetch_state_e       state_q;
  logic [SIZE_PC-1:0] pc_q;
  logic [SIZE_PC-1:0] pc_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [15:0]        recover_cnt_q;
  logic               take_ex_s;

  fetch_next_pc_mux #(.SIZE_PC(SIZE_PC)) u_mux (
    .state_i         (state_q),
    .stall_i         (bus.stall_i),
    .flagRecoverEX_i (bus.flagRecoverEX_i),
    .targetAddrEX_i  (bus.targetAddrEX_i),
    .flagRecoverID_i (bus.flagRecoverID_i),
    .targetAddrID_i  (bus.targetAddrID_i),
    .btbTaken_i      (bus.btbTaken_i),
    .btbTarget_i     (bus.btbTarget_i),
    .icacheMiss_i    (bus.icacheMiss_i),
    .pc_i            (pc_q),
    .pc_next_o       (pc_d),
    .take_ex_o       (take_ex_s),
    .fetchEn_o       (bus.fetchEn_o),
    .flushFS1_o      (bus.flushFS1_o),
    .flushFS2_o      (bus.flushFS2_o),
    .icacheCancel_o  (bus.icacheCancel_o)
  );

  // State, PC, bubble counter and recovery event counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      pc_q          <= RESET_PC;
      cnt_q         <= '0;
      recover_cnt_q <= 16'd0;
    end else begin
      pc_q <= pc_d;
      // Counts every EX recovery request, whatever state it arrives in.
      if (bus.flagRecoverEX_i) begin
        recover_cnt_q <= sat_inc16(recover_cnt_q);
      end else begin
        recover_cnt_q <= recover_cnt_q;
      end
      if (take_ex_s) begin
        // Accepted EX redirect from RUN, MISS or RECOVER (re)starts bubbles.
        if (RECOVER_BUBBLES == 0) begin
          state_q <= ST_RUN;
          cnt_q   <= '0;
        end else begin
          state_q <= ST_RECOVER;
          cnt_q   <= CNT_W'(RECOVER_BUBBLES);
        end
      end else begin
        case (state_q)
          ST_IDLE: state_q <= ST_RUN;
          ST_RUN: begin
            if (bus.icacheMiss_i) begin
              state_q <= ST_MISS;
            end else begin
              state_q <= ST_RUN;
            end
          end
          ST_MISS: begin
            if (bus.icacheFill_i) begin
              state_q <= ST_RUN;
            end else begin
              state_q <= ST_MISS;
            end
          end
          ST_RECOVER: begin
            // Leaving on cnt==1 gives exactly RECOVER_BUBBLES idle cycles;
            // stall does not pause the countdown.
            if (cnt_q <= CNT_W'(1)) begin
              state_q <= ST_RUN;
              cnt_q   <= '0;
            end else begin
              state_q <= ST_RECOVER;
              cnt_q   <= cnt_q - CNT_W'(1);
            end
          end
          default: begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

  assign bus.pc_o           = pc_q;
  assign bus.recoverCount_o = recover_cnt_q;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fetch_pc_ctrl
//   Directed vectors with hand-computed expected values for fetch_pc_ctrl.
// ---------------------------------------------------------------------------
module tb_fetch_pc_ctrl;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  fetch_pc_ctrl_if #(.SIZE_PC(32)) bus ();

  fetch_pc_ctrl #(
    .SIZE_PC         (32),
    .RESET_PC        (32'h0040_0000),
    .RECOVER_BUBBLES (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one clock edge, then settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.stall_i         = 1'b0;
    bus.flagRecoverEX_i = 1'b0;
    bus.targetAddrEX_i  = 32'h0;
    bus.flagRecoverID_i = 1'b0;
    bus.targetAddrID_i  = 32'h0;
    bus.btbTaken_i      = 1'b0;
    bus.btbTarget_i     = 32'h0;
    bus.icacheMiss_i    = 1'b0;
    bus.icacheFill_i    = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    clear_inputs();
    tick();
    tick();

    // 1. reset values, release, IDLE cycle then sequential fetch
    check("rst_pc", bus.pc_o, 32'h0040_0000);
    check("rst_fen", 32'(bus.fetchEn_o), 32'd0);
    check("rst_fl1", 32'(bus.flushFS1_o), 32'd0);
    check("rst_fl2", 32'(bus.flushFS2_o), 32'd0);
    check("rst_cancel", 32'(bus.icacheCancel_o), 32'd0);
    check("rst_rcnt", 32'(bus.recoverCount_o), 32'd0);
    reset = 1'b0;
    #1;
    check("idle_fen", 32'(bus.fetchEn_o), 32'd0);
    tick();
    check("run0_fen", 32'(bus.fetchEn_o), 32'd1);
    check("run0_pc", bus.pc_o, 32'h0040_0000);
    tick();
    check("run1_pc", bus.pc_o, 32'h0040_0020);
    tick();
    check("run2_pc", bus.pc_o, 32'h0040_0040);

    // 3. miss at 0x00400040, fill on fifth fetch-disabled cycle
    bus.icacheMiss_i = 1'b1;
    #1;
    check("miss0_fen", 32'(bus.fetchEn_o), 32'd0);
    tick();
    bus.icacheMiss_i = 1'b0;
    for (int i = 1; i < 5; i++) begin
      if (i == 4) bus.icacheFill_i = 1'b1;
      #1;
      check($sformatf("miss%0d_fen", i), 32'(bus.fetchEn_o), 32'd0);
      check($sformatf("miss%0d_pc", i), bus.pc_o, 32'h0040_0040);
      tick();
    end
    bus.icacheFill_i = 1'b0;
    check("refetch_fen", 32'(bus.fetchEn_o), 32'd1);
    check("refetch_pc", bus.pc_o, 32'h0040_0040);
    tick();
    check("post_fill_pc", bus.pc_o, 32'h0040_0060);

    // 2. ID redirect beats BTB taken
    bus.btbTaken_i      = 1'b1;
    bus.btbTarget_i     = 32'h0040_0800;
    bus.flagRecoverID_i = 1'b1;
    bus.targetAddrID_i  = 32'h0040_0100;
    #1;
    check("id_fl1", 32'(bus.flushFS1_o), 32'd1);
    check("id_fl2", 32'(bus.flushFS2_o), 32'd0);
    tick();
    clear_inputs();
    check("id_pc", bus.pc_o, 32'h0040_0100);

    // 4. EX recovery wins over same-cycle fill in MISS
    bus.icacheMiss_i = 1'b1;
    tick();
    bus.icacheMiss_i = 1'b0;
    tick();
    bus.flagRecoverEX_i = 1'b1;
    bus.targetAddrEX_i  = 32'h0040_1000;
    bus.icacheFill_i    = 1'b1;
    #1;
    check("ex_miss_fl1", 32'(bus.flushFS1_o), 32'd1);
    check("ex_miss_fl2", 32'(bus.flushFS2_o), 32'd1);
    check("ex_miss_cancel", 32'(bus.icacheCancel_o), 32'd1);
    check("ex_miss_fen", 32'(bus.fetchEn_o), 32'd0);
    tick();
    clear_inputs();
    #1;
    check("rec1_fen", 32'(bus.fetchEn_o), 32'd0);
    check("rec1_cancel", 32'(bus.icacheCancel_o), 32'd0);
    check("rec1_pc", bus.pc_o, 32'h0040_1000);
    check("rec1_rcnt", 32'(bus.recoverCount_o), 32'd1);
    tick();
    check("rec2_fen", 32'(bus.fetchEn_o), 32'd0);
    tick();
    check("rec_done_fen", 32'(bus.fetchEn_o), 32'd1);
    check("rec_done_pc", bus.pc_o, 32'h0040_1000);
    tick();
    check("rec_seq_pc", bus.pc_o, 32'h0040_1020);

    // 5. wrap at top of address space, then 3-cycle stall
    bus.flagRecoverID_i = 1'b1;
    bus.targetAddrID_i  = 32'hFFFF_FFE0;
    tick();
    clear_inputs();
    check("wrap_pre_pc", bus.pc_o, 32'hFFFF_FFE0);
    tick();
    check("wrap_pc", bus.pc_o, 32'h0000_0000);
    bus.stall_i = 1'b1;
    #1;
    check("stall0_fen", 32'(bus.fetchEn_o), 32'd0);
    tick();
    bus.flagRecoverID_i = 1'b1;
    bus.targetAddrID_i  = 32'h1234_5000;
    #1;
    check("stall1_pc", bus.pc_o, 32'h0000_0000);
    check("stall1_id_fl1", 32'(bus.flushFS1_o), 32'd0);
    check("stall1_fen", 32'(bus.fetchEn_o), 32'd0);
    tick();
    bus.flagRecoverID_i = 1'b0;
    check("stall2_pc", bus.pc_o, 32'h0000_0000);
    check("stall2_fen", 32'(bus.fetchEn_o), 32'd0);
    tick();
    bus.stall_i = 1'b0;
    #1;
    check("unstall_pc", bus.pc_o, 32'h0000_0000);
    check("unstall_fen", 32'(bus.fetchEn_o), 32'd1);
    tick();
    check("unstall_seq_pc", bus.pc_o, 32'h0000_0020);

    // 6. EX recovery from RUN, ID ignored in RECOVER, async reset at cnt=1
    bus.flagRecoverEX_i = 1'b1;
    bus.targetAddrEX_i  = 32'h0040_2000;
    #1;
    check("ex_run_fl1", 32'(bus.flushFS1_o), 32'd1);
    check("ex_run_fl2", 32'(bus.flushFS2_o), 32'd1);
    check("ex_run_cancel", 32'(bus.icacheCancel_o), 32'd0);
    tick();
    clear_inputs();
    bus.flagRecoverID_i = 1'b1;
    bus.targetAddrID_i  = 32'h0040_3000;
    #1;
    check("rec_id_fl1", 32'(bus.flushFS1_o), 32'd0);
    check("rec_rcnt2", 32'(bus.recoverCount_o), 32'd2);
    tick();
    bus.flagRecoverID_i = 1'b0;
    check("rec_cnt1_pc", bus.pc_o, 32'h0040_2000);
    #2;
    reset = 1'b1;
    #1;
    check("arst_pc", bus.pc_o, 32'h0040_0000);
    check("arst_rcnt", 32'(bus.recoverCount_o), 32'd0);
    check("arst_cancel", 32'(bus.icacheCancel_o), 32'd0);
    check("arst_fen", 32'(bus.fetchEn_o), 32'd0);
    tick();
    reset = 1'b0;
    #1;
    check("arst_idle_fen", 32'(bus.fetchEn_o), 32'd0);
    tick();
    check("arst_run_fen", 32'(bus.fetchEn_o), 32'd1);
    check("arst_run_pc", bus.pc_o, 32'h0040_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
